datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath.sv | 185 ++++++++++++++++++
 tb/tb_datapath.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath
//
// Purpose:
//   Single WIDTH-bit counter register C with an increment/decrement unit and a
//   zero/minus flag decoder. C can be cleared, loaded with C+1 / C-1, or held.
//   Priority at each rising edge: reset > c_clr > c_ld > hold.
//
// Ports (top level):
//   clk    in   1      system clock, all state updates on its rising edge
//   reset  in   1      synchronous active-high reset, forces C to 0
//   op     in   1      0 = increment, 1 = decrement
//   c_ld   in   1      load C with the arithmetic result
//   c_clr  in   1      synchronous clear of C
//   z      out  1      C == 0
//   m      out  1      C[WIDTH-1] (C negative in two's complement)
//   c_out  out  WIDTH  current value of C
//
// Sub-modules:
//   IncDec      combinational C+1 / C-1, modulo 2^WIDTH
//   CReg        the C register with reset / clear / load priority
//   FlagDecode  combinational zero and minus flags
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// IncDec
//
// Purpose:
//   Combinational incrementer/decrementer. Wraps silently modulo 2^WIDTH; no
//   carry or overflow is reported because the datapath has no error output.
//
// Ports:
//   a_i       in   WIDTH  operand (current C)
//   op_i      in   1      0 = a_i + 1, 1 = a_i - 1
//   result_o  out  WIDTH  arithmetic result
// -----------------------------------------------------------------------------
module IncDec #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             op_i,
  output logic [WIDTH-1:0] result_o
);

  // Both results are formed at full width so wrap-around falls out of the
  // natural truncation of the sum.
  logic [WIDTH-1:0] incValue;
  logic [WIDTH-1:0] decValue;

  assign incValue = a_i + WIDTH'(1);
  assign decValue = a_i - WIDTH'(1);

  always_comb begin
    result_o = incValue;
    if (op_i) begin
      result_o = decValue;
    end
  end

endmodule

// -----------------------------------------------------------------------------
// CReg
//
// Purpose:
//   The C register. Reset and clear both force zero; load takes the
//   arithmetic result; otherwise C holds regardless of op.
//
// Ports:
//   clk       in   1      clock
//   reset     in   1      synchronous active-high reset
//   clr_i     in   1      synchronous clear
//   ld_i      in   1      load enable
//   loadVal_i in   WIDTH  value to load when ld_i is set
//   c_o       out  WIDTH  current register value
// -----------------------------------------------------------------------------
module CReg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] loadVal_i,
  output logic [WIDTH-1:0] c_o
);

  logic [WIDTH-1:0] cQ;
  logic [WIDTH-1:0] cD;

  // Next-state selection. Clear wins over load, so a simultaneous clear and
  // load leaves C at zero. Reset is handled in the register itself so it
  // overrides everything, including a pending clear or load.
  always_comb begin
    cD = cQ;
    if (clr_i) begin
      cD = '0;
    end else if (ld_i) begin
      cD = loadVal_i;
    end
  end

  // State register. Reset is sampled only at the rising edge, so raising it
  // mid-cycle leaves C untouched until the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cQ <= '0;
    end else begin
      cQ <= cD;
    end
  end

  assign c_o = cQ;

endmodule

// -----------------------------------------------------------------------------
// FlagDecode
//
// Purpose:
//   Pure combinational decode of C into zero and minus flags, so the flags
//   are valid in the same cycle as c_out.
//
// Ports:
//   c_i      in   WIDTH  register value
//   zero_o   out  1      c_i == 0
//   minus_o  out  1      sign bit of c_i
// -----------------------------------------------------------------------------
module FlagDecode #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] c_i,
  output logic             zero_o,
  output logic             minus_o
);

  assign zero_o  = (c_i == '0);
  assign minus_o = c_i[WIDTH-1];

endmodule

// -----------------------------------------------------------------------------
// datapath top: wires the three units together. No state lives here other
// than the C register inside CReg.
// -----------------------------------------------------------------------------
module datapath #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op,
  input  logic             c_ld,
  input  logic             c_clr,
  output logic             z,
  output logic             m,
  output logic [WIDTH-1:0] c_out
);

  logic [WIDTH-1:0] cValue;
  logic [WIDTH-1:0] arithResult;

  IncDec #(.WIDTH(WIDTH)) uIncDec (
    .a_i      (cValue),
    .op_i     (op),
    .result_o (arithResult)
  );

  CReg #(.WIDTH(WIDTH)) uCReg (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (c_clr),
    .ld_i      (c_ld),
    .loadVal_i (arithResult),
    .c_o       (cValue)
  );

  FlagDecode #(.WIDTH(WIDTH)) uFlagDecode (
    .c_i     (cValue),
    .zero_o  (z),
    .minus_o (m)
  );

  assign c_out = cValue;

endmodule

// File: tb/tb_datapath.sv
// -----------------------------------------------------------------------------
// tb_datapath
//
// Purpose:
//   Self-checking bench for datapath. A behavioural model tracks C as an
//   integer in 0..65535 and is compared against the DUT on every falling
//   edge once the first reset has been applied. Directed sequences also
//   check hand-computed literal values at key points.
// -----------------------------------------------------------------------------
module tb_datapath;

  localparam int WIDTH = 16;
  localparam int MODULUS = 65536;

  logic             clk;
  logic             reset;
  logic             op;
  logic             c_ld;
  logic             c_clr;
  logic             z;
  logic             m;
  logic [WIDTH-1:0] c_out;

  int testsRun;
  int testsFailed;

  int modelC;
  bit modelValid;

  datapath #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .c_ld  (c_ld),
    .c_clr (c_clr),
    .z     (z),
    .m     (m),
    .c_out (c_out)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: C as a plain integer, updated by the priority rules
  // with modulo arithmetic. Becomes meaningful after the first reset edge.
  always @(posedge clk) begin
    if (reset) begin
      modelC     <= 0;
      modelValid <= 1'b1;
    end else if (c_clr) begin
      modelC <= 0;
    end else if (c_ld) begin
      if (op) begin
        modelC <= (modelC + MODULUS - 1) % MODULUS;
      end else begin
        modelC <= (modelC + 1) % MODULUS;
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model, away from the
  // active edge. Flags are derived from the integer value, not from bits.
  always @(negedge clk) begin
    if (modelValid) begin
      testsRun++;
      if ((int'(c_out) != modelC) || (z !== (modelC == 0)) ||
          (m !== (modelC >= MODULUS / 2))) begin
        testsFailed++;
        $display("[TB] FAIL model_cycle: c_out=%h z=%b m=%b, required c_out=%h z=%b m=%b",
                 c_out, z, m, modelC[15:0], (modelC == 0), (modelC >= MODULUS / 2));
      end
    end
  end

  // Drive one cycle's inputs, let the rising edge take them, and return
  // shortly after the edge so outputs can be checked.
  task automatic applyStimulus(input logic r, input logic clr,
                               input logic ld, input logic o);
    reset = r;
    c_clr = clr;
    c_ld  = ld;
    op    = o;
    @(posedge clk);
    #2;
  endtask

  // Literal check of outputs against hand-computed values.
  task automatic checkOutput(input string name, input logic [WIDTH-1:0] expC,
                             input logic expZ, input logic expM);
    testsRun++;
    if (c_out !== expC || z !== expZ || m !== expM) begin
      testsFailed++;
      $display("[TB] FAIL %s: c_out=%h z=%b m=%b, required c_out=%h z=%b m=%b",
               name, c_out, z, m, expC, expZ, expM);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    modelC      = 0;
    modelValid  = 1'b0;
    reset = 1'b0;
    c_clr = 1'b0;
    c_ld  = 1'b0;
    op    = 1'b0;
    @(posedge clk);
    #2;

    // Reset held two cycles, release, then a clear pulse.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_1", 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("clear_after_reset", 16'h0000, 1'b1, 1'b0);

    // Three increments from zero.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("inc_1", 16'h0001, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("inc_2", 16'h0002, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("inc_3", 16'h0003, 1'b0, 1'b0);

    // Decrements down through zero into the negative range.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("dec_2", 16'h0002, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("dec_1", 16'h0001, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("dec_0", 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("dec_wrap", 16'hFFFF, 1'b0, 1'b1);

    // Increment wrap-around from 0xFFFF.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("inc_wrap", 16'h0000, 1'b1, 1'b0);

    // Reach 0x7FFF by decrementing 0x8001 times from zero, then cross the
    // signed overflow boundary with one increment.
    for (int i = 0; i < 32769; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    end
    checkOutput("at_7fff", 16'h7FFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("overflow_8000", 16'h8000, 1'b0, 1'b1);

    // Clear takes priority over load with C = 5.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("at_5", 16'h0005, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("clr_over_ld", 16'h0000, 1'b1, 1'b0);

    // Hold with op toggling and load disabled.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("hold_op1", 16'h0002, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_op0", 16'h0002, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("hold_op1b", 16'h0002, 1'b0, 1'b0);

    // Reset mid-run of increments at C = 3: no change before the edge.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("at_3", 16'h0003, 1'b0, 1'b0);
    reset = 1'b1;
    c_ld  = 1'b1;
    op    = 1'b0;
    #1;
    checkOutput("reset_before_edge", 16'h0003, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("reset_over_ld", 16'h0000, 1'b1, 1'b0);

    // First load after reset release works from zero.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("first_ld_after_reset", 16'h0001, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
